max7219_spi_rx: RTL and testbench
=================================

Name: max7219_spi_rx

Overview:
- Receiver end of the 3-wire display link (DIN/CS/SCLK) that the traffic-light controller drives toward its MAX7219-style LED driver.
- Oversamples the serial lines in the system clock domain and assembles 16-bit frames.
- Decodes each frame into a MAX7219-compatible register file: 8 digit registers plus decode-mode, intensity, scan-limit, shutdown and display-test.
- Used as an on-chip loopback monitor and as a behavioural display model for verification of the transmitter.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages in each input synchronizer (minimum 2).
FRAME_BITS, 16, serial frame length in bits, MSB first.

Ports:
clk  input  1  system clock; must be at least 4x the SCLK frequency.
rst  input  1  synchronous, active-high reset.
din_in  input  1  serial data, asynchronous to clk.
cs_in  input  1  chip select, active low, asynchronous to clk.
sclk_in  input  1  serial clock; data is sampled on the rising edge. Asynchronous to clk.
frame_valid_out  output  1  one-cycle pulse when a complete frame has been latched.
frame_addr_out  output  4  address nibble (bits 11:8) of the last valid frame.
frame_data_out  output  8  data byte (bits 7:0) of the last valid frame.
frame_err_out  output  1  one-cycle pulse when CS rises with fewer than FRAME_BITS bits received.
digits_out  output  64  digit registers 0..7; digit n occupies bits [8n+7:8n].
decode_mode_out  output  8  decode-mode register (address 0x9).
intensity_out  output  4  intensity register (address 0xA), bits 3:0.
scan_limit_out  output  3  scan-limit register (address 0xB), bits 2:0.
shutdown_n_out  output  1  shutdown register (address 0xC) bit 0; 0 means shutdown.
display_test_out  output  1  display-test register (address 0xF) bit 0.

Behaviour:
- Input conditioning: each of din_in, cs_in and sclk_in passes through a SYNC_STAGES synchronizer. Edges are detected on the synchronized CS and SCLK against a one-cycle-delayed copy.
- Reset: all outputs, the shift register and the bit counter go to 0; the FSM goes to WAIT_HIGH. Reset mid-frame discards the partial frame and produces no error pulse.
- FSM states:
  - WAIT_HIGH: wait for synchronized CS = 1, then go to IDLE. This prevents latching a frame whose start was missed.
  - IDLE: on a CS falling edge, clear the bit counter and shift register, then go to SHIFT.
  - SHIFT: on each SCLK rising edge, shift the synchronized DIN into the LSB. The 5-bit bit counter increments and saturates at FRAME_BITS. When more than FRAME_BITS bits arrive, the last FRAME_BITS are retained. On a CS rising edge, go to LATCH.
  - LATCH: a single cycle, then return to IDLE.
    - If count == FRAME_BITS: pulse frame_valid_out, update frame_addr_out and frame_data_out, and write the register file in the same cycle.
    - Otherwise: pulse frame_err_out; the register file is unchanged.
- Edge priority: if an SCLK rising edge and a CS rising edge are detected in the same cycle, the SCLK edge is shifted first, then the CS edge is processed.
- SCLK edges while CS is high are ignored.
- Register map:
  - 0x0: no-op; frame_valid_out still pulses.
  - 0x1..0x8: digit 0..7.
  - 0x9: decode-mode.
  - 0xA: intensity.
  - 0xB: scan-limit.
  - 0xC: shutdown.
  - 0xF: display-test.
  - 0xD and 0xE: no register write, but frame_valid_out still pulses.
  - Bits 15:12 of the frame are don't-care.
- Latency: frame_valid_out asserts SYNC_STAGES+2 clk cycles after the raw cs_in rising edge.
- Register outputs hold their values between frames. Back-to-back frames are supported provided CS stays high for at least SYNC_STAGES+2 clk cycles.

Decomposition:
- Package max7219_pkg:
  - Register address constants: ADDR_NOOP, ADDR_DIGIT0 through ADDR_DIGIT7, ADDR_DECODE, ADDR_INTENSITY, ADDR_SCANLIMIT, ADDR_SHUTDOWN, ADDR_TEST.
  - FRAME_BITS default.
  - FSM state encoding (WAIT_HIGH, IDLE, SHIFT, LATCH).
- Sub-module sync_edge: a SYNC_STAGES synchronizer plus rise/fall detector. It is instantiated for CS and SCLK; DIN uses the synchronizer path only.

Test Plan:
1. Reset, then send frame 0x0C01 with SCLK at clk/8 -> one frame_valid_out pulse; frame_addr_out = 0xC, frame_data_out = 0x01, shutdown_n_out = 1, all other registers 0.
2. Send 0x0A0F then 0x0B07 back-to-back with the minimum CS-high gap -> intensity_out = 0xF, scan_limit_out = 7, exactly two frame_valid_out pulses, frame_err_out never asserted.
3. Send 0x035A then 0x08A5 -> digits_out[23:16] = 0x5A and digits_out[63:56] = 0xA5; all other digit bytes 0.
4. Send only 10 SCLK pulses, then raise CS -> one frame_err_out pulse, no frame_valid_out, all registers unchanged.
5. Send 24 bits 0xFF_0901 in one CS window -> frame accepted as 0x0901; decode_mode_out = 0x01.
6. Assert rst after 8 bits of 0x0F01, release it with CS still low, finish the frame -> no pulses and display_test_out = 0; the next full 0x0F01 frame sets display_test_out = 1.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219-style serial receiver.
// Covers the register map, the default frame length and the receiver FSM states.
package max7219_pkg;

    localparam int DEFAULT_FRAME_BITS = 16;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        LATCH     = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous line, with rise/fall detection
// against a one-cycle-delayed copy of the synchronized value.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_out,
    output logic fall_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise_out = sync_out & ~prev_q;
    assign fall_out = ~sync_out & prev_q;

endmodule

// File: rtl/max7219_spi_rx.sv
// Oversampling receiver for the DIN/CS/SCLK display link; assembles frames
// and maintains a MAX7219-compatible register file.
module max7219_spi_rx
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = DEFAULT_FRAME_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_in,
    input  logic        cs_in,
    input  logic        sclk_in,
    output logic        frame_valid_out,
    output logic [3:0]  frame_addr_out,
    output logic [7:0]  frame_data_out,
    output logic        frame_err_out,
    output logic [63:0] digits_out,
    output logic [7:0]  decode_mode_out,
    output logic [3:0]  intensity_out,
    output logic [2:0]  scan_limit_out,
    output logic        shutdown_n_out,
    output logic        display_test_out
);

    localparam int CNT_W     = $clog2(FRAME_BITS + 1);
    localparam int KEEP_BITS = 12;

    rx_state_t state_q, state_d;

    logic                   cs_sync, cs_rise, cs_fall;
    logic                   sclk_rise;
    logic                   sclk_sync_unused, sclk_fall_unused;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   din_sync;
    logic [KEEP_BITS-1:0]   shift_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic                   latch_valid, latch_err;
    logic [3:0]             rx_addr;
    logic [7:0]             rx_data;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (cs_in),
        .sync_out (cs_sync),
        .rise_out (cs_rise),
        .fall_out (cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sclk_in),
        .sync_out (sclk_sync_unused),
        .rise_out (sclk_rise),
        .fall_out (sclk_fall_unused)
    );

    // DIN goes through the same depth as SCLK so a sampled bit lines up with its edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_sync_q <= '0;
        end else begin
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din_in};
        end
    end

    assign din_sync = din_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_HIGH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_HIGH: if (cs_sync) state_d = IDLE;
            IDLE:      if (cs_fall) state_d = SHIFT;
            SHIFT:     if (cs_rise) state_d = LATCH;
            LATCH:     state_d = IDLE;
            default:   state_d = WAIT_HIGH;
        endcase
    end

    always_comb begin
        latch_valid = 1'b0;
        latch_err   = 1'b0;
        if (state_q == LATCH) begin
            if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
                latch_valid = 1'b1;
            end else begin
                latch_err = 1'b1;
            end
        end
    end

    // Only the low 12 bits of a frame carry address and data, so older bits fall off.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (state_q == IDLE && cs_fall) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (state_q == SHIFT && sclk_rise) begin
            shift_q <= {shift_q[KEEP_BITS-2:0], din_sync};
            if (bit_cnt_q != CNT_W'(FRAME_BITS)) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    assign rx_addr = shift_q[11:8];
    assign rx_data = shift_q[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid_out  <= 1'b0;
            frame_err_out    <= 1'b0;
            frame_addr_out   <= '0;
            frame_data_out   <= '0;
            digits_out       <= '0;
            decode_mode_out  <= '0;
            intensity_out    <= '0;
            scan_limit_out   <= '0;
            shutdown_n_out   <= 1'b0;
            display_test_out <= 1'b0;
        end else begin
            frame_valid_out <= latch_valid;
            frame_err_out   <= latch_err;
            if (latch_valid) begin
                frame_addr_out <= rx_addr;
                frame_data_out <= rx_data;
                for (int n = 0; n < 8; n++) begin
                    if (rx_addr == ADDR_DIGIT0 + 4'(n)) begin
                        digits_out[8*n +: 8] <= rx_data;
                    end
                end
                case (rx_addr)
                    ADDR_DECODE:    decode_mode_out  <= rx_data;
                    ADDR_INTENSITY: intensity_out    <= rx_data[3:0];
                    ADDR_SCANLIMIT: scan_limit_out   <= rx_data[2:0];
                    ADDR_SHUTDOWN:  shutdown_n_out   <= rx_data[0];
                    ADDR_TEST:      display_test_out <= rx_data[0];
                    default:        ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_max7219_spi_rx.sv
// Scoreboard bench for max7219_spi_rx: stimulus pushes expected frame events,
// a negedge monitor pops and compares them whenever the receiver pulses.
module tb_max7219_spi_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_in;
    logic        cs_in;
    logic        sclk_in;
    logic        frame_valid_out;
    logic [3:0]  frame_addr_out;
    logic [7:0]  frame_data_out;
    logic        frame_err_out;
    logic [63:0] digits_out;
    logic [7:0]  decode_mode_out;
    logic [3:0]  intensity_out;
    logic [2:0]  scan_limit_out;
    logic        shutdown_n_out;
    logic        display_test_out;

    typedef struct {
        logic       is_err;
        logic [3:0] addr;
        logic [7:0] data;
    } frame_exp_t;

    frame_exp_t sb[$];
    int passCount  = 0;
    int checkCount = 0;

    max7219_spi_rx #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .din_in           (din_in),
        .cs_in            (cs_in),
        .sclk_in          (sclk_in),
        .frame_valid_out  (frame_valid_out),
        .frame_addr_out   (frame_addr_out),
        .frame_data_out   (frame_data_out),
        .frame_err_out    (frame_err_out),
        .digits_out       (digits_out),
        .decode_mode_out  (decode_mode_out),
        .intensity_out    (intensity_out),
        .scan_limit_out   (scan_limit_out),
        .shutdown_n_out   (shutdown_n_out),
        .display_test_out (display_test_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Any pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (frame_valid_out === 1'b1 || frame_err_out === 1'b1)) begin
            if (sb.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b, expected no pulse",
                         frame_valid_out, frame_err_out);
            end else begin
                frame_exp_t e;
                e = sb.pop_front();
                checkOutput("pulse_kind", {62'd0, frame_valid_out, frame_err_out}, {62'd0, ~e.is_err, e.is_err});
                checkOutput("frame_addr", {60'd0, frame_addr_out}, {60'd0, e.addr});
                checkOutput("frame_data", {56'd0, frame_data_out}, {56'd0, e.data});
            end
        end
    end

    task automatic pushExpect(input logic is_err, input logic [3:0] addr, input logic [7:0] data);
        frame_exp_t e;
        e.is_err = is_err;
        e.addr   = addr;
        e.data   = data;
        sb.push_back(e);
    endtask

    task automatic csLow();
        cs_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // SCLK runs at clk/8: four clk cycles low, four high, MSB first.
    task automatic shiftBits(input logic [31:0] value, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            din_in  = value[nbits-1-i];
            sclk_in = 1'b0;
            repeat (4) @(negedge clk);
            sclk_in = 1'b1;
            repeat (4) @(negedge clk);
        end
        sclk_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic csHigh(input int gap);
        cs_in = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [31:0] value, input int nbits, input int gap);
        csLow();
        shiftBits(value, nbits);
        csHigh(gap);
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        checkCount++;
        if (sb.size() == 0) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d frame events still pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic checkRegs(input logic [63:0] digits, input logic [7:0] decode, input logic [3:0] inten,
                             input logic [2:0] scan, input logic sd_n, input logic test);
        checkOutput("digits",       digits_out,                 digits);
        checkOutput("decode_mode",  {56'd0, decode_mode_out},   {56'd0, decode});
        checkOutput("intensity",    {60'd0, intensity_out},     {60'd0, inten});
        checkOutput("scan_limit",   {61'd0, scan_limit_out},    {61'd0, scan});
        checkOutput("shutdown_n",   {63'd0, shutdown_n_out},    {63'd0, sd_n});
        checkOutput("display_test", {63'd0, display_test_out},  {63'd0, test});
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        cs_in   = 1'b1;
        sclk_in = 1'b0;
        din_in  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] reset state");
        checkRegs(64'd0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
        checkOutput("reset_addr", {60'd0, frame_addr_out}, 64'd0);
        checkOutput("reset_data", {56'd0, frame_data_out}, 64'd0);

        $display("[TB] shutdown frame");
        pushExpect(1'b0, 4'hC, 8'h01);
        applyStimulus(32'h0C01, 16, 10);
        waitDrain("drain_shutdown");
        checkRegs(64'd0, 8'h00, 4'h0, 3'd0, 1'b1, 1'b0);

        $display("[TB] back-to-back intensity and scan-limit");
        pushExpect(1'b0, 4'hA, 8'h0F);
        pushExpect(1'b0, 4'hB, 8'h07);
        applyStimulus(32'h0A0F, 16, 4);
        applyStimulus(32'h0B07, 16, 10);
        waitDrain("drain_back_to_back");
        checkRegs(64'd0, 8'h00, 4'hF, 3'd7, 1'b1, 1'b0);

        $display("[TB] digit writes");
        pushExpect(1'b0, 4'h3, 8'h5A);
        pushExpect(1'b0, 4'h8, 8'hA5);
        applyStimulus(32'h035A, 16, 10);
        applyStimulus(32'h08A5, 16, 10);
        waitDrain("drain_digits");
        checkRegs(64'hA500_0000_005A_0000, 8'h00, 4'hF, 3'd7, 1'b1, 1'b0);

        $display("[TB] short frame");
        pushExpect(1'b1, 4'h8, 8'hA5);
        applyStimulus(32'h0000_02AA, 10, 10);
        waitDrain("drain_short");
        checkRegs(64'hA500_0000_005A_0000, 8'h00, 4'hF, 3'd7, 1'b1, 1'b0);

        $display("[TB] long frame keeps last 16 bits");
        pushExpect(1'b0, 4'h9, 8'h01);
        applyStimulus(32'h00FF_0901, 24, 10);
        waitDrain("drain_long");
        checkRegs(64'hA500_0000_005A_0000, 8'h01, 4'hF, 3'd7, 1'b1, 1'b0);

        $display("[TB] unmapped and no-op addresses");
        pushExpect(1'b0, 4'hD, 8'h55);
        pushExpect(1'b0, 4'h0, 8'h77);
        applyStimulus(32'h0D55, 16, 10);
        applyStimulus(32'h0077, 16, 10);
        waitDrain("drain_noop");
        checkRegs(64'hA500_0000_005A_0000, 8'h01, 4'hF, 3'd7, 1'b1, 1'b0);

        $display("[TB] reset in the middle of a frame");
        csLow();
        shiftBits(32'h0F, 8);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        shiftBits(32'h01, 8);
        csHigh(10);
        repeat (20) @(negedge clk);
        waitDrain("drain_mid_reset");
        checkRegs(64'd0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
        checkOutput("mid_reset_addr", {60'd0, frame_addr_out}, 64'd0);

        pushExpect(1'b0, 4'hF, 8'h01);
        applyStimulus(32'h0F01, 16, 10);
        waitDrain("drain_test_after_reset");
        checkRegs(64'd0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b1);

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
